// File: rtl/rect_wr_pkg.sv
// rect_wr_pkg: shared state encoding, beat geometry and frame-buffer address packing for the rectangle writer.
package rect_wr_pkg;
  typedef enum logic [2:0] {IDLE, LINE_START, REQ, BURSTING, SEG_END, LINE_END} state_t;
  localparam int PIX_PER_BEAT = 4;
  function automatic logic [24:0] pack_addr(input logic [1:0] bank, input logic [10:0] line, input logic [8:0] xb);
    return {bank, line, xb, 3'b000};
  endfunction
endpackage

// File: rtl/burst_segmenter.sv
// burst_segmenter: splits a span into BURST_LEN-sized bursts, tracking the current burst address and beats left.
module burst_segmenter #(
  parameter int BURST_LEN = 128,
  parameter int ADDR_W = 27
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] span_addr,
  input  logic [9:0]        span_len,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [9:0]        burst_len,
  output logic [9:0]        remaining,
  output logic              last
);
  logic [9:0] rem;
  assign last = rem <= 10'(BURST_LEN);
  assign burst_len = last ? rem : 10'(BURST_LEN);
  assign remaining = rem - burst_len;
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_addr <= '0;
      rem <= '0;
    end else if (load) begin
      burst_addr <= span_addr;
      rem <= span_len;
    end else if (advance) begin
      burst_addr <= burst_addr + ADDR_W'({burst_len, 3'b000});
      rem <= remaining;
    end
  end
endmodule

// File: rtl/rect_burst_writer.sv
// rect_burst_writer: paints rectangle outlines into the frame buffer as write bursts.
// Define RECT_FILL_EN to honour rect_fill and draw filled rectangles.
module rect_burst_writer
  import rect_wr_pkg::*;
#(
  parameter int BURST_LEN = 128,
  parameter int COORD_W = 11,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 27
) (
  input  logic               mem_clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [1:0]         frame_addr,
  input  logic               rect_valid,
  output logic               rect_ready,
  input  logic [COORD_W-1:0] rect_x1,
  input  logic [COORD_W-1:0] rect_y1,
  input  logic [COORD_W-1:0] rect_x2,
  input  logic [COORD_W-1:0] rect_y2,
  input  logic [15:0]        rect_color,
  input  logic               rect_fill,
  output logic               wr_burst_req,
  output logic [ADDR_W-1:0]  wr_burst_addr,
  output logic [9:0]         wr_burst_len,
  output logic [DATA_W-1:0]  wr_burst_data,
  input  logic               wr_burst_data_req,
  input  logic               burst_finish,
  output logic               busy,
  output logic               rect_done,
  output logic               rect_err
);
  state_t state, state_n;
  logic [COORD_W-1:0] y1_q, y2_q, line;
  logic [8:0] xb1_q, xb2_q;
  logic [1:0] bank_q;
  logic fill_q, pend2, abort_q, fin_q;
  logic bad, take, full, abort_now, seg_load, seg_adv, seg_last;
  logic [9:0] seg_len_in, seg_rem;
  logic [ADDR_W-1:0] seg_addr_in;
  assign bad = rect_x1 > rect_x2 || rect_y1 > rect_y2;
  assign take = state == IDLE && rect_valid && !bad;
  assign full = fill_q || line == y1_q || line == y2_q;
  assign abort_now = abort_q || frame_start;
  assign seg_load = state == LINE_START || (state == SEG_END && !abort_now && seg_last && pend2);
  assign seg_adv = state == SEG_END && !abort_now && !seg_last;
  assign seg_addr_in = ADDR_W'(pack_addr(bank_q, 11'(line), state == LINE_START ? xb1_q : xb2_q));
  assign seg_len_in = (state == LINE_START && full) ? 10'(xb2_q) - 10'(xb1_q) + 10'd1 : 10'd1;
  assign rect_ready = rst_n && state == IDLE;
  assign busy = state != IDLE;
  assign wr_burst_req = state == REQ;
  assign rect_done = state == LINE_END && !frame_start && line == y2_q;
  burst_segmenter #(.BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) u_seg (
    .mem_clk(mem_clk),
    .rst_n(rst_n),
    .load(seg_load),
    .advance(seg_adv),
    .span_addr(seg_addr_in),
    .span_len(seg_len_in),
    .burst_addr(wr_burst_addr),
    .burst_len(wr_burst_len),
    .remaining(seg_rem),
    .last(seg_last)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = take ? LINE_START : IDLE;
      LINE_START: state_n = frame_start ? IDLE : REQ;
      REQ:        state_n = frame_start ? IDLE : (wr_burst_data_req || burst_finish) ? BURSTING : REQ;
      BURSTING:   state_n = (burst_finish || fin_q) ? SEG_END : BURSTING;
      SEG_END:    state_n = abort_now ? IDLE : (seg_rem != 10'd0 || pend2) ? REQ : LINE_END;
      LINE_END:   state_n = (frame_start || line == y2_q) ? IDLE : LINE_START;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y1_q <= '0;
      y2_q <= '0;
      line <= '0;
      xb1_q <= '0;
      xb2_q <= '0;
      bank_q <= '0;
      pend2 <= 1'b0;
      abort_q <= 1'b0;
      fin_q <= 1'b0;
      rect_err <= 1'b0;
      wr_burst_data <= '0;
    end else begin
      state <= state_n;
      rect_err <= state == IDLE && rect_valid && bad;
      fin_q <= state == REQ ? burst_finish : (state == BURSTING ? 1'b0 : fin_q);
      if (take) begin
        y1_q <= rect_y1;
        y2_q <= rect_y2;
        line <= rect_y1;
        xb1_q <= 9'(rect_x1 >> $clog2(PIX_PER_BEAT));
        xb2_q <= 9'(rect_x2 >> $clog2(PIX_PER_BEAT));
        bank_q <= frame_addr;
        abort_q <= 1'b0;
        wr_burst_data <= DATA_W'({PIX_PER_BEAT{rect_color}});
      end else if ((state == BURSTING || state == SEG_END) && frame_start) begin
        abort_q <= 1'b1;
      end
      if (state == LINE_START) pend2 <= !full && xb1_q != xb2_q;
      else if (state == SEG_END && seg_load) pend2 <= 1'b0;
      if (state == LINE_END && line != y2_q) line <= line + 1'b1;
    end
  end
`ifdef RECT_FILL_EN
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) fill_q <= 1'b0;
    else if (take) fill_q <= rect_fill;
  end
`else
  logic unused_fill;
  assign fill_q = 1'b0;
  assign unused_fill = rect_fill;
`endif
endmodule
